// File: rtl/lfsr_crypt_engine.sv
// rtl/lfsr_crypt_engine.sv - streaming LFSR cipher, one fixed-length frame per Start
// Encrypt pads around a clamped message window; decrypt strips keystream and counts parity errors.
module lfsr_crypt_engine #(
  parameter int LFSR_W  = 7,
  parameter int DATA_W  = LFSR_W + 1,
  parameter int MSG_LEN = 64,
  parameter int PRE_MIN = 10,
  parameter int PRE_MAX = 26,
  parameter logic [DATA_W-1:0] PAD_CHAR = 8'h20
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  output logic                       Ack,
  input  logic                       cfg_mode,
  input  logic [LFSR_W-1:0]          cfg_taps,
  input  logic [LFSR_W-1:0]          cfg_seed,
  input  logic [7:0]                 cfg_pre_len,
  input  logic [7:0]                 cfg_msg_len,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(MSG_LEN)-1:0] out_index,
  output logic [7:0]                 par_err_cnt
);

  localparam int IDX_W = $clog2(MSG_LEN);
  localparam int POS_W = IDX_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_mode;
  logic [LFSR_W-1:0] r_taps;
  logic [LFSR_W-1:0] r_lfsr;
  logic [7:0]        r_pre;
  logic [8:0]        r_msg_end;
  logic [POS_W-1:0]  r_pos;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_index;
  logic              r_out_valid;
  logic [7:0]        r_par_cnt;

  logic [7:0]        w_pre_eff;
  logic [7:0]        w_room;
  logic [7:0]        w_len_eff;
  logic [8:0]        w_pos9;
  logic              w_in_msg;
  logic              w_need_in;
  logic              w_active;
  logic              w_can_load;
  logic              w_load;
  logic              w_start_ok;
  logic              w_last_take;
  logic              w_par_bad;
  logic [DATA_W-2:0] w_plain_low;
  logic [DATA_W-2:0] w_enc_low;
  logic [DATA_W-1:0] w_enc;
  logic [DATA_W-1:0] w_dec;
  logic [LFSR_W-1:0] w_lfsr_next;

  always_comb begin
    w_pre_eff = cfg_pre_len;
    if (cfg_pre_len < 8'(PRE_MIN)) w_pre_eff = 8'(PRE_MIN);
    else if (cfg_pre_len > 8'(PRE_MAX)) w_pre_eff = 8'(PRE_MAX);
  end

  assign w_room    = 8'(MSG_LEN) - w_pre_eff;
  assign w_len_eff = (cfg_msg_len < w_room) ? cfg_msg_len : w_room;

  assign w_pos9      = 9'(r_pos);
  assign w_in_msg    = (w_pos9 >= {1'b0, r_pre}) && (w_pos9 < r_msg_end);
  // Decrypt consumes every slot; encrypt only inside the message window.
  assign w_need_in   = r_mode || w_in_msg;
  assign w_active    = (r_state == S_RUN) && (r_pos < POS_W'(MSG_LEN));
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_load      = w_active && w_can_load && (!w_need_in || in_valid);
  assign w_start_ok  = Start && (r_state != S_RUN);
  assign w_last_take = r_out_valid && out_ready && (r_out_index == IDX_W'(MSG_LEN - 1));

  assign w_plain_low = w_in_msg ? in_data[DATA_W-2:0] : PAD_CHAR[DATA_W-2:0];
  assign w_enc_low   = w_plain_low ^ r_lfsr;
  assign w_enc       = {^w_enc_low, w_enc_low};
  assign w_dec       = {1'b0, in_data[DATA_W-2:0] ^ r_lfsr};
  assign w_par_bad   = in_data[DATA_W-1] != (^in_data[DATA_W-2:0]);
  assign w_lfsr_next = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & r_taps)};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_taps      <= '0;
      r_lfsr      <= '0;
      r_pre       <= '0;
      r_msg_end   <= '0;
      r_pos       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_par_cnt   <= '0;
    end else if (w_start_ok) begin
      r_state     <= S_RUN;
      r_mode      <= cfg_mode;
      r_taps      <= cfg_taps;
      r_lfsr      <= (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
      r_pre       <= w_pre_eff;
      r_msg_end   <= {1'b0, w_pre_eff} + {1'b0, w_len_eff};
      r_pos       <= '0;
      r_out_valid <= 1'b0;
      r_par_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_out_data  <= r_mode ? w_dec : w_enc;
        r_out_index <= r_pos[IDX_W-1:0];
        r_out_valid <= 1'b1;
        r_pos       <= r_pos + 1'b1;
        r_lfsr      <= w_lfsr_next;
        if (r_mode && w_par_bad && (r_par_cnt != 8'hFF)) r_par_cnt <= r_par_cnt + 8'd1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_last_take) r_state <= S_DONE;
    end
  end

  assign Ack         = (r_state == S_DONE);
  assign in_ready    = w_active && w_need_in && w_can_load;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_index   = r_out_index;
  assign par_err_cnt = r_par_cnt;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb/tb_lfsr_crypt_engine.sv - scoreboard bench for lfsr_crypt_engine
// Driver pushes expected frames into a queue; a negedge monitor pops and compares.
module tb_lfsr_crypt_engine;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack, cfg_mode;
  logic [6:0] cfg_taps, cfg_seed;
  logic [7:0] cfg_pre_len, cfg_msg_len, in_data, out_data, par_err_cnt;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [5:0] out_index;

  lfsr_crypt_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .cfg_mode(cfg_mode), .cfg_taps(cfg_taps), .cfg_seed(cfg_seed),
    .cfg_pre_len(cfg_pre_len), .cfg_msg_len(cfg_msg_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .par_err_cnt(par_err_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] d;
    logic [5:0] idx;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         n_out = 0;
  int         last_cyc, last_k, last_acks, n_msg;
  logic [7:0] cap[0:63];
  logic [7:0] msg[0:63];
  logic [7:0] src[0:63];
  logic [7:0] plain_f[0:63];
  logic [7:0] ciph_f[0:63];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [5:0] prev_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(out_valid && out_data === prev_d && out_index === prev_i)) begin
          failures++;
          $display("FAIL hold: got v=%0b d=%0h i=%0d expected d=%0h i=%0d",
                   out_valid, out_data, out_index, prev_d, prev_i);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got d=%0h i=%0d expected none", out_data, out_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.d || out_index !== e.idx) begin
            failures++;
            $display("FAIL out_byte: got d=%0h i=%0d expected d=%0h i=%0d",
                     out_data, out_index, e.d, e.idx);
          end
        end
        cap[out_index] = out_data;
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_i     = out_index;
    end
  end

  // Reference frame built from the cipher definition: padded plaintext and ciphertext.
  task automatic build(input logic [6:0] taps, input logic [6:0] seed, input int pre, input int len);
    logic [6:0] l;
    logic [7:0] p, c;
    int pe, le;
    pe = (pre < 10) ? 10 : ((pre > 26) ? 26 : pre);
    le = (len < 64 - pe) ? len : 64 - pe;
    n_msg = le;
    l = (seed == 7'd0) ? 7'd1 : seed;
    for (int i = 0; i < 64; i++) begin
      p = (i >= pe && i < pe + le) ? msg[i - pe] : 8'h20;
      plain_f[i] = p;
      c = p ^ {1'b0, l};
      c[7] = ^c[6:0];
      ciph_f[i] = c;
      l = {l[5:0], ^(l & taps)};
    end
  endtask

  task automatic push_enc();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({ciph_f[i], 6'(i)});
      src[i] = msg[i];
    end
  endtask

  task automatic push_dec();
    for (int i = 0; i < 64; i++) exp_q.push_back({{1'b0, plain_f[i][6:0]}, 6'(i)});
  endtask

  task automatic set_cfg(input logic mode, input logic [6:0] taps, input logic [6:0] seed,
                         input logic [7:0] pre, input logic [7:0] len);
    cfg_mode = mode; cfg_taps = taps; cfg_seed = seed; cfg_pre_len = pre; cfg_msg_len = len;
  endtask

  task automatic run_frame(input int nframes, input bit stall, input bit bubble, input bit hold,
                           input int abort_at, input int n_in);
    int k, cyc, acks;
    bit fin;
    n_out = 0;
    @(posedge Clk); #1;
    Start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    k = 0; cyc = 0; acks = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge Clk); #1;
      Start     = hold;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (k < n_in) && (!bubble || $urandom_range(0, 3) != 0);
      in_data   = src[k % 64];
      @(negedge Clk);
      cyc++;
      if (in_valid && in_ready) k++;
      if (Ack) begin
        acks++;
        if (acks == nframes) fin = 1'b1;
        else k = 0;
      end
      if (abort_at > 0 && n_out >= abort_at) fin = 1'b1;
      if (cyc >= 5000) begin
        checks++; failures++;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        fin = 1'b1;
      end
    end
    Start = 1'b0; in_valid = 1'b0;
    last_cyc = cyc; last_k = k; last_acks = acks;
  endtask

  initial begin
    string s;
    s = "Mr. Watson, come here. I want to see you.";
    for (int i = 0; i < 64; i++) msg[i] = (i < s.len()) ? s[i] : 8'h00;
    Reset = 1'b1; Start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    set_cfg(1'b0, 7'h60, 7'h01, 8'd10, 8'd41);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_index", 32'(out_index), 0);
    chk("rst_par", 32'(par_err_cnt), 0);
    @(posedge Clk); #1 Reset = 1'b0;

    // Golden encrypt frame with hand-computed bytes.
    set_cfg(1'b0, 7'h60, 7'h01, 8'd10, 8'd41);
    build(7'h60, 7'h01, 10, 41); push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("enc_cycles", 32'(last_cyc), 66);
    chk("enc_inputs", 32'(last_k), 41);
    chk("enc_done_ack", 32'(Ack), 1);
    chk("enc_done_valid", 32'(out_valid), 0);
    chk("enc_out0", 32'(cap[0]), 32'h21);
    chk("enc_out1", 32'(cap[1]), 32'h22);
    chk("enc_out3", 32'(cap[3]), 32'h28);
    chk("enc_out5", 32'(cap[5]), 32'h00);
    chk("enc_out6", 32'(cap[6]), 32'hE1);
    chk("enc_out9", 32'(cap[9]), 32'hAC);
    chk("enc_out10", 32'(cap[10]), 32'h55);
    chk("enc_q_empty", 32'(exp_q.size()), 0);

    // Preamble below minimum and zero seed.
    set_cfg(1'b0, 7'h60, 7'h00, 8'd3, 8'd41);
    build(7'h60, 7'h00, 3, 41); push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("clamp_lo_out0", 32'(cap[0]), 32'h21);
    chk("clamp_lo_out10", 32'(cap[10]), 32'h55);
    chk("clamp_lo_inputs", 32'(last_k), 41);

    // Preamble above maximum clips the message length.
    set_cfg(1'b0, 7'h60, 7'h01, 8'd40, 8'd41);
    build(7'h60, 7'h01, 40, 41); push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("clamp_hi_inputs", 32'(last_k), 38);
    chk("clamp_hi_q_empty", 32'(exp_q.size()), 0);

    // Empty message gives an all-pad frame; then zero taps.
    set_cfg(1'b0, 7'h60, 7'h01, 8'd10, 8'd0);
    build(7'h60, 7'h01, 10, 0); push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("allpad_inputs", 32'(last_k), 0);
    set_cfg(1'b0, 7'h00, 7'h55, 8'd20, 8'd41);
    build(7'h00, 7'h55, 20, 41); push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("taps0_q_empty", 32'(exp_q.size()), 0);

    // Random backpressure and input bubbles.
    set_cfg(1'b0, 7'h60, 7'h01, 8'd10, 8'd41);
    build(7'h60, 7'h01, 10, 41); push_enc();
    run_frame(1, 1, 1, 0, 0, n_msg);
    chk("bp_count", 32'(n_out), 64);
    chk("bp_q_empty", 32'(exp_q.size()), 0);

    // Round-trip decrypt; pre/len inputs must be ignored.
    set_cfg(1'b1, 7'h60, 7'h01, 8'd40, 8'd0);
    build(7'h60, 7'h01, 10, 41); push_dec();
    for (int i = 0; i < 64; i++) src[i] = ciph_f[i];
    run_frame(1, 0, 0, 0, 0, 64);
    chk("dec_par0", 32'(par_err_cnt), 0);
    chk("dec_inputs", 32'(last_k), 64);
    push_dec();
    src[5][7] = ~src[5][7];
    src[17][7] = ~src[17][7];
    run_frame(1, 1, 0, 0, 0, 64);
    chk("dec_par2", 32'(par_err_cnt), 2);
    chk("dec_q_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-frame, then a clean frame.
    set_cfg(1'b0, 7'h60, 7'h01, 8'd10, 8'd41);
    build(7'h60, 7'h01, 10, 41); push_enc();
    run_frame(1, 0, 0, 0, 30, n_msg);
    #2 Reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_out_index", 32'(out_index), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_ack", 32'(Ack), 0);
    exp_q.delete();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    push_enc();
    run_frame(1, 0, 0, 0, 0, n_msg);
    chk("arst_refr_cycles", 32'(last_cyc), 66);
    chk("arst_refr_q_empty", 32'(exp_q.size()), 0);

    // Start held high: back-to-back frames, mid-frame Start ignored.
    push_enc(); push_enc();
    run_frame(2, 0, 0, 1, 0, n_msg);
    chk("b2b_acks", 32'(last_acks), 2);
    chk("b2b_count", 32'(n_out), 128);
    chk("b2b_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
